// File: rtl/frame_stream_sequencer.sv
// Frame I/O sequencer: raster fetch from source memory, credit-limited streaming to the filter
// core, border-substituting writeback. Define FRAME_SEQ_CHECKSUM_EN to add a running output checksum.
module frame_stream_sequencer #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int DW     = 8,
  parameter int AW     = 16,
  parameter int BORDER = 5,
  parameter int FIFO_D = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          mem_rd,
  output logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          px_valid,
  output logic [DW-1:0] px_data,
  input  logic          res_valid,
  input  logic [DW-1:0] res_data,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          finish,
  output logic          err,
  output logic [31:0]   checksum
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = $clog2(FIFO_D);
  localparam int CW = $clog2(FIFO_D + 1);
  localparam bit BORDER_EN = (BORDER != 0);

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] W_A       = AW'(IMG_W);
  localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_LO      = XW'(BORDER);
  localparam logic [XW-1:0] X_HI      = XW'(IMG_W - BORDER);
  localparam logic [YW-1:0] Y_LO      = YW'(BORDER);
  localparam logic [YW-1:0] Y_HI      = YW'(IMG_H - BORDER);
  localparam logic [XW-1:0] X_ONE     = XW'(1);
  localparam logic [YW-1:0] Y_ONE     = YW'(1);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] CREDITS   = CW'(FIFO_D);
  localparam logic [PW:0]   P_ONE     = (PW + 1)'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic            w_mem_rd;
  logic            w_start_acc;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [XW-1:0]   r_ox;
  logic [YW-1:0]   r_oy;
  logic [CW-1:0]   r_inflight;
  logic            r_px_valid;
  logic [DW-1:0]   r_fifo [FIFO_D];
  logic [PW:0]     r_wr_ptr;
  logic [PW:0]     r_rd_ptr;
  logic            r_out_valid;
  logic [AW-1:0]   r_out_addr;
  logic [DW-1:0]   r_out_data;
  logic            r_busy;
  logic            r_finish;
  logic            r_err;
  logic [AW-1:0]   w_in_addr;
  logic [AW-1:0]   w_out_addr;
  logic            w_res_ok;
  logic            w_res_err;
  logic            w_fifo_empty;
  logic [DW-1:0]   w_pop_data;
  logic            w_border;

  assign w_in_addr    = (AW'(r_y) * W_A) + AW'(r_x);
  assign w_out_addr   = (AW'(r_oy) * W_A) + AW'(r_ox);
  assign w_res_ok     = res_valid && (r_inflight != {CW{1'b0}});
  assign w_res_err    = res_valid && (r_inflight == {CW{1'b0}});
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  // A zero-latency core can return a result in the same cycle its pixel is being pushed.
  assign w_pop_data   = w_fifo_empty ? in_data : r_fifo[r_rd_ptr[PW-1:0]];
  assign w_border     = BORDER_EN && ((r_ox < X_LO) || (r_ox >= X_HI) ||
                                      (r_oy < Y_LO) || (r_oy >= Y_HI));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = S_RUN; else w_state_nx = S_IDLE;
      S_RUN:   if (w_mem_rd && (w_in_addr == LAST_ADDR)) w_state_nx = S_DRAIN; else w_state_nx = S_RUN;
      S_DRAIN: if (r_out_valid && (r_out_addr == LAST_ADDR)) w_state_nx = S_DONE; else w_state_nx = S_DRAIN;
      S_DONE:  if (start) w_state_nx = S_RUN; else w_state_nx = S_DONE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_mem_rd    = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE:  w_start_acc = start;
      S_RUN:   w_mem_rd = (r_inflight < CREDITS);
      S_DRAIN: w_mem_rd = 1'b0;
      S_DONE:  w_start_acc = start;
      default: w_mem_rd = 1'b0;
    endcase
  end

  // Raster fetch counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= {XW{1'b0}};
      r_y <= {YW{1'b0}};
    end else if (w_start_acc) begin
      r_x <= {XW{1'b0}};
      r_y <= {YW{1'b0}};
    end else if (w_mem_rd) begin
      if (r_x == X_LAST) begin
        r_x <= {XW{1'b0}};
        r_y <= (r_y == Y_LAST) ? {YW{1'b0}} : (r_y + Y_ONE);
      end else begin
        r_x <= r_x + X_ONE;
      end
    end
  end

  // Credit counter and pixel-valid delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= {CW{1'b0}};
      r_px_valid <= 1'b0;
    end else begin
      r_px_valid <= w_mem_rd;
      case ({w_mem_rd, w_res_ok})
        2'b10:   r_inflight <= r_inflight + C_ONE;
        2'b01:   r_inflight <= r_inflight - C_ONE;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Source FIFO storage (no reset needed: entries are only read after being written)
  always_ff @(posedge clk) begin
    if (r_px_valid) r_fifo[r_wr_ptr[PW-1:0]] <= in_data;
  end

  // Source FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {(PW + 1){1'b0}};
      r_rd_ptr <= {(PW + 1){1'b0}};
    end else begin
      if (r_px_valid) r_wr_ptr <= r_wr_ptr + P_ONE;
      if (w_res_ok)   r_rd_ptr <= r_rd_ptr + P_ONE;
    end
  end

  // Writeback counters and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ox        <= {XW{1'b0}};
      r_oy        <= {YW{1'b0}};
      r_out_valid <= 1'b0;
      r_out_addr  <= {AW{1'b0}};
      r_out_data  <= {DW{1'b0}};
    end else if (w_start_acc) begin
      r_ox        <= {XW{1'b0}};
      r_oy        <= {YW{1'b0}};
      r_out_valid <= 1'b0;
    end else if (w_res_ok) begin
      r_out_valid <= 1'b1;
      r_out_addr  <= w_out_addr;
      r_out_data  <= w_border ? w_pop_data : res_data;
      if (r_ox == X_LAST) begin
        r_ox <= {XW{1'b0}};
        r_oy <= (r_oy == Y_LAST) ? {YW{1'b0}} : (r_oy + Y_ONE);
      end else begin
        r_ox <= r_ox + X_ONE;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  // Status flags; err is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_busy   <= (w_state_nx == S_RUN) || (w_state_nx == S_DRAIN);
      r_finish <= (w_state_nx == S_DONE);
      r_err    <= r_err | w_res_err;
    end
  end

`ifdef FRAME_SEQ_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Wrap-around sum of every written pixel in the current frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_checksum <= 32'd0;
    else if (w_start_acc) r_checksum <= 32'd0;
    else if (r_out_valid) r_checksum <= r_checksum + 32'(r_out_data);
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'd0;
`endif

  assign mem_rd    = w_mem_rd;
  assign in_addr   = w_in_addr;
  assign px_valid  = r_px_valid;
  assign px_data   = r_px_valid ? in_data : {DW{1'b0}};
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign finish    = r_finish;
  assign err       = r_err;

endmodule

// File: tb/tb_frame_stream_sequencer.sv
// Scoreboard bench for frame_stream_sequencer on a 16x16 image, BORDER=2, FIFO_D=8,
// with a behavioural source memory and a fixed-latency core model.
module tb_frame_stream_sequencer;
  localparam int W = 16, H = 16, LAT = 3, NPIX = W * H;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        mem_rd, px_valid, out_valid, busy, finish, err;
  logic [15:0] in_addr, out_addr;
  logic [7:0]  in_data = 8'd0, px_data, out_data;
  logic        res_valid = 1'b0;
  logic [7:0]  res_data = 8'd0;
  logic [31:0] checksum;

  frame_stream_sequencer #(.IMG_W(W), .IMG_H(H), .DW(8), .AW(16), .BORDER(2), .FIFO_D(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_rd(mem_rd), .in_addr(in_addr),
    .in_data(in_data), .px_valid(px_valid), .px_data(px_data), .res_valid(res_valid),
    .res_data(res_data), .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .finish(finish), .err(err), .checksum(checksum));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  pat = 8'd0;
  bit          core_const = 1'b0, core_hold = 1'b0, force_res = 1'b0;
  int          n_cmp = 0, n_mis = 0;
  logic [23:0] sb[$];
  int          nrd, nout;
  logic [31:0] exp_sum;
  int          core_due[$];
  logic [7:0]  core_dat[$];

  function automatic logic [7:0] src_px(input logic [15:0] a);
    return a[7:0] ^ pat;
  endfunction

  function automatic bit is_border(input logic [15:0] a);
    logic [3:0] x;
    logic [3:0] y;
    x = a[3:0];
    y = a[7:4];
    return (x < 4'd2) || (x > 4'd13) || (y < 4'd2) || (y > 4'd13);
  endfunction

  function automatic logic [7:0] exp_px(input logic [15:0] a);
    return (is_border(a) || !core_const) ? src_px(a) : 8'hAA;
  endfunction

  function automatic logic [31:0] exp_ck(input logic [31:0] s);
`ifdef FRAME_SEQ_CHECKSUM_EN
    return s;
`else
    return 32'd0 & s;
`endif
  endfunction

  // Source memory: data valid the cycle after the address
  always @(posedge clk) in_data <= src_px(in_addr);

  // Core model: in-order, LAT cycles, optional hold, constant output or forced stray result
  always @(negedge clk) begin
    if (!rst_n) begin
      core_due.delete();
      core_dat.delete();
      res_valid = 1'b0;
      res_data  = 8'd0;
    end else begin
      if (px_valid) begin
        core_due.push_back(cyc + LAT);
        core_dat.push_back(px_data);
      end
      if (force_res) begin
        res_valid = 1'b1;
        res_data  = 8'h77;
      end else if (!core_hold && core_due.size() > 0 && core_due[0] <= cyc) begin
        res_valid = 1'b1;
        res_data  = core_const ? 8'hAA : core_dat[0];
        void'(core_due.pop_front());
        void'(core_dat.pop_front());
      end else begin
        res_valid = 1'b0;
        res_data  = 8'd0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Record an expected write for every fetch seen this cycle
  task automatic mon_sample();
    logic [7:0] d;
    if (mem_rd) begin
      nrd++;
      d = exp_px(in_addr);
      sb.push_back({in_addr, d});
      exp_sum += {24'd0, d};
    end
  endtask

  task automatic clear_sb();
    sb.delete();
    nrd = 0;
    nout = 0;
    exp_sum = 32'd0;
  endtask

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({mem_rd, in_addr, px_valid, px_data, out_valid, out_addr, out_data, busy, finish, err, checksum} !== 86'd0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %h want 0", {mem_rd, in_addr, px_valid, px_data, out_valid,
               out_addr, out_data, busy, finish, err, checksum});
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (out_valid || mem_rd || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_mis++; $display("FAIL idle_quiet: activity=%0b want 0", seen); end
  endtask

  task automatic test_full_frame();
    logic [23:0] e;
    int n, last_out;
    core_const = 1'b0; pat = 8'h00; clear_sb();
    pulse_start();
    n_cmp++;
    if ({mem_rd, in_addr} !== 17'h10000) begin n_mis++; $display("FAIL ff_first_rd: got %b/%h want 1/0000", mem_rd, in_addr); end
    n = 0; last_out = -10;
    while (finish !== 1'b1 && n < 2000) begin
      mon_sample();
      if (out_valid) begin
        nout++; n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 24'hxxxxxx;
        if ({out_addr, out_data} !== e) begin n_mis++; $display("FAIL ff_pixel: got %h/%h want %h/%h", out_addr, out_data, e[23:8], e[7:0]); end
        if (out_addr == 16'd255) last_out = cyc;
      end
      tick(); n++;
    end
    n_cmp++;
    if (finish !== 1'b1 || cyc != last_out + 1) begin n_mis++; $display("FAIL ff_finish: finish=%b cyc=%0d want 1 at %0d", finish, cyc, last_out + 1); end
    n_cmp++;
    if (nrd != NPIX || nout != NPIX) begin n_mis++; $display("FAIL ff_counts: rd=%0d out=%0d want %0d", nrd, nout, NPIX); end
    n_cmp++;
    if (busy !== 1'b0 || checksum !== exp_ck(exp_sum)) begin n_mis++; $display("FAIL ff_done: busy=%b ck=%h want 0/%h", busy, checksum, exp_ck(exp_sum)); end
  endtask

  task automatic test_credit_stall();
    logic [23:0] e;
    int n, fr, fm;
    core_hold = 1'b1; clear_sb();
    pulse_start();
    repeat (20) begin mon_sample(); tick(); end
    n_cmp++;
    if (nrd != 8 || mem_rd !== 1'b0) begin n_mis++; $display("FAIL cs_stall: rd=%0d mem_rd=%b want 8/0", nrd, mem_rd); end
    core_hold = 1'b0;
    n = 0; fr = -1; fm = -1;
    while (finish !== 1'b1 && n < 2000) begin
      if (res_valid && fr < 0) fr = cyc;
      if (mem_rd && fm < 0) fm = cyc;
      mon_sample();
      if (out_valid) begin
        nout++; n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 24'hxxxxxx;
        if ({out_addr, out_data} !== e) begin n_mis++; $display("FAIL cs_pixel: got %h/%h want %h/%h", out_addr, out_data, e[23:8], e[7:0]); end
      end
      tick(); n++;
    end
    n_cmp++;
    if (fr < 0 || fm != fr + 1) begin n_mis++; $display("FAIL cs_resume: rd at %0d want %0d", fm, fr + 1); end
    n_cmp++;
    if (finish !== 1'b1 || nout != NPIX) begin n_mis++; $display("FAIL cs_finish: finish=%b out=%0d want 1/%0d", finish, nout, NPIX); end
  endtask

  task automatic test_border();
    logic [23:0] e;
    int n, n_int;
    core_const = 1'b1; pat = 8'h3C; clear_sb();
    pulse_start();
    n = 0; n_int = 0;
    while (finish !== 1'b1 && n < 2000) begin
      mon_sample();
      if (out_valid) begin
        nout++; n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 24'hxxxxxx;
        if ({out_addr, out_data} !== e) begin n_mis++; $display("FAIL bd_pixel: got %h/%h want %h/%h", out_addr, out_data, e[23:8], e[7:0]); end
        if (!is_border(out_addr) && out_data == 8'hAA) n_int++;
      end
      tick(); n++;
    end
    n_cmp++;
    if (n_int != 144 || finish !== 1'b1) begin n_mis++; $display("FAIL bd_interior: got %0d finish=%b want 144/1", n_int, finish); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] e;
    int n;
    core_const = 1'b0; pat = 8'h5A; clear_sb();
    pulse_start();
    n_cmp++;
    if ({finish, busy, mem_rd, in_addr} !== 19'h30000) begin n_mis++; $display("FAIL bb_restart: fin=%b busy=%b rd=%b addr=%h want 0/1/1/0000", finish, busy, mem_rd, in_addr); end
    n = 0;
    while (finish !== 1'b1 && n < 2000) begin
      mon_sample();
      if (out_valid) begin
        nout++; n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 24'hxxxxxx;
        if ({out_addr, out_data} !== e) begin n_mis++; $display("FAIL bb_pixel: got %h/%h want %h/%h", out_addr, out_data, e[23:8], e[7:0]); end
      end
      tick(); n++;
    end
    n_cmp++;
    if (finish !== 1'b1 || nout != NPIX || checksum !== exp_ck(exp_sum)) begin
      n_mis++; $display("FAIL bb_done: fin=%b out=%0d ck=%h want 1/%0d/%h", finish, nout, checksum, NPIX, exp_ck(exp_sum));
    end
  endtask

  task automatic test_protocol_error();
    bit seen;
    n_cmp++;
    if (err !== 1'b0) begin n_mis++; $display("FAIL pe_pre: err=%b want 0", err); end
    force_res = 1'b1;
    tick();
    force_res = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick(); if (out_valid) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0 || err !== 1'b1) begin n_mis++; $display("FAIL pe_drop: out_valid_seen=%b err=%b want 0/1", seen, err); end
    repeat (10) tick();
    n_cmp++;
    if (err !== 1'b1) begin n_mis++; $display("FAIL pe_sticky: err=%b want 1", err); end
  endtask

  task automatic test_midframe_reset();
    logic [23:0] e;
    int n;
    core_const = 1'b0; pat = 8'h00; clear_sb();
    pulse_start();
    n = 0;
    while (nrd < 100 && n < 500) begin mon_sample(); tick(); n++; end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_rd, in_addr, px_valid, px_data, out_valid, out_addr, out_data, busy, finish, err, checksum} !== 86'd0) begin
      n_mis++;
      $display("FAIL mr_outputs: got %h want 0", {mem_rd, in_addr, px_valid, px_data, out_valid,
               out_addr, out_data, busy, finish, err, checksum});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    clear_sb();
    pulse_start();
    n_cmp++;
    if ({mem_rd, in_addr} !== 17'h10000) begin n_mis++; $display("FAIL mr_first_rd: got %b/%h want 1/0000", mem_rd, in_addr); end
    n = 0;
    while (finish !== 1'b1 && n < 2000) begin
      mon_sample();
      if (out_valid) begin
        nout++; n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 24'hxxxxxx;
        if ({out_addr, out_data} !== e) begin n_mis++; $display("FAIL mr_pixel: got %h/%h want %h/%h", out_addr, out_data, e[23:8], e[7:0]); end
      end
      tick(); n++;
    end
    n_cmp++;
    if (finish !== 1'b1 || nout != NPIX || checksum !== exp_ck(32'd32640) || sb.size() != 0) begin
      n_mis++; $display("FAIL mr_done: fin=%b out=%0d ck=%h left=%0d want 1/%0d/%h/0", finish, nout, checksum, sb.size(), NPIX, exp_ck(32'd32640));
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_credit_stall();
    test_border();
    test_back_to_back();
    test_protocol_error();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
